// File: rtl/instruc_fetch_pkg.sv
// Shared fetch/decode definitions: widths, reset PC, NOP encoding, opcode field.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instruc_fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    RESET_PC_DEF  = 32'd0;
    localparam logic [PC_W-1:0]    PC_STEP_DEF   = 32'd1;
    localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'd0;

    // Opcode lives in the top nibble of every instruction word.
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;

    typedef enum logic [3:0] {
        OPC_NOP = 4'h0,
        OPC_INC = 4'h1,
        OPC_SUB = 4'h2,
        OPC_LD  = 4'h3,
        OPC_BRZ = 4'h4,
        OPC_BRN = 4'h5,
        OPC_J   = 4'h6
    } opcode_e;

    function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] instr);
        return opcode_e'(instr[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/instruc_fetch_ifid_reg.sv
// IF/ID pipeline register with flush, hold and load; resets to a NOP bubble.
// Latency: 1 cycle from load inputs to registered outputs.
// Backpressure: hold freezes all outputs; flush beats hold and inserts a bubble.
module ifid_reg
    import instruc_fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               hold,
    input  logic               load,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [PC_W-1:0]    pc_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               vld_out
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               vld_q, vld_d;

    // Next-state selection: flush > hold > load > bubble.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end else if (hold) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            vld_d   = vld_q;
        end else if (load) begin
            instr_d = instr_in;
            pc_d    = pc_in;
            vld_d   = 1'b1;
        end else begin
            instr_d = NOP_INSTR;
            vld_d   = 1'b0;
        end
    end

    // Register with synchronous reset to an invalid NOP at PC 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            vld_q   <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            vld_q   <= vld_d;
        end
    end

    assign instr_out = instr_q;
    assign pc_out    = pc_q;
    assign vld_out   = vld_q;

endmodule

// File: rtl/instruc_fetch.sv
// Fetch stage: drives imem address, tracks one in-flight read, fills IF/ID.
// Latency: address issued at edge N appears in IF/ID after edge N+1.
// Backpressure: stall replays the in-flight address and holds IF/ID; redirect wins.
module instruc_fetch
    import instruc_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = RESET_PC_DEF,
    parameter logic [PC_W-1:0]    PC_STEP   = PC_STEP_DEF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    instrucAddress,
    input  logic [INSTR_W-1:0] instruc,
    input  logic               stall,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirectTarget,
    output logic [INSTR_W-1:0] ifidInstruc,
    output logic [PC_W-1:0]    ifidPc,
    output logic               ifidValid
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;
    logic            inflight_vld_q, inflight_vld_d;
    logic [PC_W-1:0] req_addr;

    // Request address: reset > redirect > replay of the in-flight fetch > sequential PC.
    always_comb begin
        req_addr = pc_q;
        if (rst) begin
            req_addr = RESET_PC;
        end else if (redirect) begin
            req_addr = redirectTarget;
        end else if (stall && inflight_vld_q) begin
            req_addr = inflight_pc_q;
        end
    end

    assign instrucAddress = req_addr;

    // Whatever is requested this cycle becomes the in-flight read; PC advances past it (wraps mod 2^32).
    always_comb begin
        pc_d           = req_addr + PC_STEP;
        inflight_pc_d  = req_addr;
        inflight_vld_d = 1'b1;
    end

    // PC and in-flight tracking; reset drops any outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            inflight_pc_q  <= RESET_PC;
            inflight_vld_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            inflight_pc_q  <= inflight_pc_d;
            inflight_vld_q <= inflight_vld_d;
        end
    end

    // Arriving read data lands in IF/ID only when neither flushed nor stalled.
    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .hold      (stall),
        .load      (inflight_vld_q),
        .instr_in  (instruc),
        .pc_in     (inflight_pc_q),
        .instr_out (ifidInstruc),
        .pc_out    (ifidPc),
        .vld_out   (ifidValid)
    );

endmodule

// File: tb/tb_instruc_fetch.sv
// Directed bench for instruc_fetch with a 32-entry registered imem model.
// Latency: checks IF/ID one cycle after each applied input vector.
// Backpressure: exercises stall, redirect, redirect+stall, mid-stream reset, PC wrap.
module tb_instruc_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] instrucAddress;
    logic [31:0] instruc;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] ifidInstruc;
    logic [31:0] ifidPc;
    logic        ifidValid;

    int n_checks;
    int n_fail;

    logic [31:0] mem [32];

    instruc_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .instrucAddress (instrucAddress),
        .instruc        (instruc),
        .stall          (stall),
        .redirect       (redirect),
        .redirectTarget (redirectTarget),
        .ifidInstruc    (ifidInstruc),
        .ifidPc         (ifidPc),
        .ifidValid      (ifidValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered instruction memory, aliased on the low five address bits.
    always @(posedge clk) instruc <= mem[instrucAddress[4:0]];

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] exp_addr;
        logic        exp_vld;
        logic        chk_pc;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check the address before the edge and IF/ID after it.
    task automatic apply(input vec_t v, input string tag);
        rst            = v.rst;
        stall          = v.stall;
        redirect       = v.redirect;
        redirectTarget = v.target;
        #1;
        check({tag, " addr"}, instrucAddress, v.exp_addr);
        @(posedge clk);
        #1;
        check({tag, " valid"}, {31'd0, ifidValid}, {31'd0, v.exp_vld});
        check({tag, " instr"}, ifidInstruc, v.exp_instr);
        if (v.chk_pc) check({tag, " pc"}, ifidPc, v.exp_pc);
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [31:0] t, input logic [31:0] a,
                                input logic ev, input logic cp, input logic [31:0] p,
                                input logic [31:0] ins);
        vec_t v;
        v.rst = r; v.stall = s; v.redirect = rd; v.target = t; v.exp_addr = a;
        v.exp_vld = ev; v.chk_pc = cp; v.exp_pc = p; v.exp_instr = ins;
        return v;
    endfunction

    localparam logic [31:0] B = 32'hA000_0000;

    vec_t tbl [$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem[i] = B + 32'(i);
        rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirectTarget = 32'd0;

        //        rst   stl   rdr   target        addr          vld   chkpc pc            instr
        // reset
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 1'b1, 32'd0,        32'd0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 1'b1, 32'd0,        32'd0));
        // free run: first valid on second edge after reset drops
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd0,        1'b0, 1'b0, 32'd0,        32'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd1,        1'b1, 1'b1, 32'd0,        B + 0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd2,        1'b1, 1'b1, 32'd1,        B + 1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd3,        1'b1, 1'b1, 32'd2,        B + 2));
        // stall three cycles while pc 2 sits in IF/ID; replay address 3
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0,        32'd3,        1'b1, 1'b1, 32'd2,        B + 2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0,        32'd3,        1'b1, 1'b1, 32'd2,        B + 2));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 32'd0,        32'd3,        1'b1, 1'b1, 32'd2,        B + 2));
        // release: 3, 4, 5 back-to-back
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd4,        1'b1, 1'b1, 32'd3,        B + 3));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd5,        1'b1, 1'b1, 32'd4,        B + 4));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd6,        1'b1, 1'b1, 32'd5,        B + 5));
        // redirect to 14: one bubble, pc 6 never shows
        tbl.push_back(mk(1'b0, 1'b0, 1'b1, 32'd14,       32'd14,       1'b0, 1'b0, 32'd0,        32'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd15,       1'b1, 1'b1, 32'd14,       B + 14));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd16,       1'b1, 1'b1, 32'd15,       B + 15));
        // redirect and stall together: flush wins, target 1 requested
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 32'd1,        32'd1,        1'b0, 1'b0, 32'd0,        32'd0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd2,        1'b1, 1'b1, 32'd1,        B + 1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 32'd0,        32'd3,        1'b1, 1'b1, 32'd2,        B + 2));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Mid-stream reset for one cycle discards in-flight work and restarts at RESET_PC.
        apply(mk(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 32'd0, 32'd0), "rst_mid");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0), "rst_restart0");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b1, 32'd0, B + 0), "rst_restart1");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b1, 32'd1, B + 1), "rst_restart2");

        // Redirect to the top of the address space; PC wraps to zero with no side effect.
        apply(mk(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0), "wrap_redir");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, B + 31), "wrap_top");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd1, 1'b1, 1'b1, 32'd0, B + 0), "wrap_zero");
        apply(mk(1'b0, 1'b0, 1'b0, 32'd0, 32'd2, 1'b1, 1'b1, 32'd1, B + 1), "wrap_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
